// File: rtl/softmax_unit_p_pkg.sv
// Shared types and width helpers for the fixed-point softmax unit.
// The state order is the processing order: capture, max scan, exp, sum, divide, hand off.
package softmax_unit_p_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAX  = 3'd1,
        S_EXP  = 3'd2,
        S_SUM  = 3'd3,
        S_DIV  = 3'd4,
        S_DONE = 3'd5
    } state_e;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic int fx_one(input int frac);
        return 1 << frac;
    endfunction

    // The sum of N values each <= 1.0 needs $clog2(N) extra integer bits.
    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    // Dividend is e shifted left by FRAC so the quotient lands in FRAC fractional bits.
    function automatic int div_width(input int w, input int frac);
        return w + frac;
    endfunction

endpackage

// File: rtl/softmax_unit_p_divider.sv
// Unsigned restoring divider producing Q_W quotient bits, one bit per cycle after a start cycle.
// The caller guarantees the quotient fits in Q_W bits, so only the low Q_W dividend bits are shifted in.
module seq_divider #(
    parameter int DVD_W = 24,
    parameter int DVS_W = 20,
    parameter int Q_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CW = $clog2(Q_W);

    logic             active_r;
    logic [CW-1:0]    cnt_r;
    logic [DVS_W-1:0] rem_r;
    logic [DVS_W-1:0] dvs_r;
    logic [Q_W-1:0]   dvd_r;
    logic [Q_W-1:0]   quot_r;

    logic [DVS_W:0]   trial;
    logic             ge;
    logic [DVS_W-1:0] rem_nx;
    logic [Q_W-1:0]   quot_nx;

    always_comb begin
        trial   = {rem_r, dvd_r[Q_W-1]};
        ge      = (trial >= {1'b0, dvs_r});
        rem_nx  = ge ? DVS_W'(trial - {1'b0, dvs_r}) : DVS_W'(trial);
        quot_nx = Q_W'({quot_r, ge});
    end

    // done and quotient are valid during the final iteration cycle so the caller loses no cycle.
    assign busy     = active_r;
    assign done     = active_r && (cnt_r == CW'(Q_W - 1));
    assign quotient = quot_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            cnt_r    <= '0;
            rem_r    <= '0;
            dvs_r    <= '0;
            dvd_r    <= '0;
            quot_r   <= '0;
        end else if (start && !active_r) begin
            rem_r    <= DVS_W'(dividend >> Q_W);
            dvd_r    <= Q_W'(dividend);
            dvs_r    <= divisor;
            quot_r   <= '0;
            cnt_r    <= '0;
            active_r <= 1'b1;
        end else if (active_r) begin
            rem_r  <= rem_nx;
            dvd_r  <= dvd_r << 1;
            quot_r <= quot_nx;
            cnt_r  <= cnt_r + CW'(1);
            if (done) active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/softmax_unit_p.sv
// Fixed-latency softmax over N signed fixed-point logits with a 2nd-order exp approximation.
// Handshake: a vector transfers when in_valid && in_ready; a result is consumed when out_valid && out_ready.
module softmax_unit_p
    import softmax_unit_p_pkg::*;
#(
    parameter int N    = 10,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*W-1:0]       out_data,
    output logic [$clog2(N)-1:0] out_argmax,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output state_e               dbg_state
);

    localparam int IW  = $clog2(N);
    localparam int SW  = sum_width(W, N);
    localparam int DW  = div_width(W, FRAC);
    localparam int QW  = FRAC + 1;
    localparam int ONE = fx_one(FRAC);

    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W:0]   ONE_X    = (W+1)'(ONE);
    localparam logic signed [W:0]   NEG_ONE  = (W+1)'(-ONE);

    state_e state_r, state_nx;

    logic [IW-1:0]       idx_r;
    logic                last;
    logic signed [W-1:0] v_r [N];
    logic [W-1:0]        e_r [N];
    logic [W-1:0]        q_r [N];
    logic signed [W-1:0] max_r;
    logic [IW-1:0]       amax_r;
    logic [SW-1:0]       sum_r;

    logic signed [W:0]     x;
    logic signed [2*W+1:0] sq;
    logic signed [W:0]     e_w;
    logic [W-1:0]          e_val;

    logic          div_start, div_busy, div_done;
    logic [QW-1:0] div_q;

    assign last = (idx_r == IW'(N - 1));

    // x <= 0 always; below -1.0 the quadratic is no longer a useful fit, so e is forced to 0.
    always_comb begin
        x     = (W+1)'(v_r[idx_r]) - (W+1)'(max_r);
        sq    = (2*W+2)'(x) * (2*W+2)'(x);
        e_w   = ONE_X + x + (W+1)'(sq >>> (FRAC + 1));
        e_val = (x >= NEG_ONE) ? W'(e_w) : '0;
    end

    seq_divider #(
        .DVD_W (DW),
        .DVS_W (SW),
        .Q_W   (QW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DW'(e_r[idx_r]) << FRAC),
        .divisor  (sum_r),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_nx;
    end

    always_comb begin
        state_nx  = state_r;
        in_ready  = (state_r == S_IDLE);
        out_valid = (state_r == S_DONE);
        busy      = (state_r != S_IDLE);
        div_start = (state_r == S_DIV) && !div_busy;
        dbg_state = state_r;
        case (state_r)
            S_IDLE:  if (in_valid)             state_nx = S_MAX;
            S_MAX:   if (last)                 state_nx = S_EXP;
            S_EXP:   if (last)                 state_nx = S_SUM;
            S_SUM:   if (last)                 state_nx = S_DIV;
            S_DIV:   if (div_done && last)     state_nx = S_DONE;
            S_DONE:  if (out_ready)            state_nx = S_IDLE;
            default:                           state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r      <= '0;
            max_r      <= MOST_NEG;
            amax_r     <= '0;
            sum_r      <= '0;
            out_data   <= '0;
            out_argmax <= '0;
            for (int i = 0; i < N; i++) begin
                v_r[i] <= '0;
                e_r[i] <= '0;
                q_r[i] <= '0;
            end
        end else begin
            case (state_r)
                S_IDLE: if (in_valid) begin
                    for (int i = 0; i < N; i++) v_r[i] <= in_data[i*W +: W];
                    max_r  <= MOST_NEG;
                    amax_r <= '0;
                    sum_r  <= '0;
                    idx_r  <= '0;
                end
                S_MAX: begin
                    if (v_r[idx_r] > max_r) begin
                        max_r  <= v_r[idx_r];
                        amax_r <= idx_r;
                    end
                    idx_r <= last ? '0 : idx_r + IW'(1);
                end
                S_EXP: begin
                    e_r[idx_r] <= e_val;
                    idx_r      <= last ? '0 : idx_r + IW'(1);
                end
                S_SUM: begin
                    sum_r <= sum_r + SW'(e_r[idx_r]);
                    idx_r <= last ? '0 : idx_r + IW'(1);
                end
                S_DIV: if (div_done) begin
                    q_r[idx_r] <= W'(div_q);
                    idx_r      <= last ? '0 : idx_r + IW'(1);
                    // Results publish only on DONE entry; the last quotient bypasses q_r.
                    if (last) begin
                        for (int j = 0; j < N; j++)
                            out_data[j*W +: W] <= (j == N - 1) ? W'(div_q) : q_r[j];
                        out_argmax <= amax_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/softmax_unit_p.md
SOFTMAX_UNIT_P -- requirements
Module: softmax_unit_p

Interface
REQ-001 Parameter N, default 10: number of logits/classes, 2..32.
REQ-002 Parameter W, default 16: logit/output width, signed two's complement.
REQ-003 Parameter FRAC, default 8: fractional bits. Default format is Q8.8.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_data  in  N*W  logits; element i at [i*W +: W].
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_ready  out  1  block can accept a vector.
REQ-009 out_data  out  N*W  probabilities, unsigned fixed-point, FRAC fractional bits.
REQ-010 out_argmax  out  $clog2(N)  index of the largest logit.
REQ-011 out_valid  out  1  out_data and out_argmax valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, MAX, EXP, SUM, DIV, DONE, in that order. DONE returns to IDLE.
REQ-015 in_ready SHALL equal (state==IDLE). A transfer occurs only when in_valid and in_ready are both high.
REQ-016 On transfer, in_data SHALL be copied into an internal N-entry register. All later stages read only that copy, so in_data may change freely after transfer.
REQ-017 MAX (N cycles): one element per cycle; max starts at the most negative W-bit value; strict greater-than.
- argmax = lowest index on ties.
REQ-018 EXP (N cycles): x = v[i] - max, computed in W+1 bits, so x <= 0.
- If x >= -1.0: e = 1.0 + x + (x*x >>> (FRAC+1)).
- Otherwise e = 0.
- e is W bits unsigned, with 0 <= e <= 1.0.
REQ-019 The maximum element SHALL therefore have e = 1.0. Sum >= 1.0 and division by zero cannot occur.
REQ-020 SUM (N cycles): sum accumulated in W+$clog2(N) bits with no truncation.
REQ-021 DIV: per element, q = (e << FRAC) / sum, truncated.
- Uses a sequential restoring divider: 1 start cycle plus FRAC+1 iteration cycles, i.e. FRAC+2 cycles per element.
- q <= 1.0 is guaranteed and is written zero-extended to W bits.
REQ-022 Latency SHALL be fixed. out_valid rises exactly 3N + N*(FRAC+2) + 1 cycles after the transfer cycle (131 for the defaults).
REQ-023 DONE: out_valid=1, and out_data/out_argmax are held stable until out_valid && out_ready. The block then goes to IDLE on the next edge and out_valid drops.
REQ-024 If out_ready is already high on DONE entry, out_valid SHALL be high for exactly one cycle.
REQ-025 in_valid during any non-IDLE state SHALL be ignored. There is no queuing.
REQ-026 out_data SHALL retain the last result after handshake until the next DONE. It updates only on DONE entry, never mid-DIV.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL enter IDLE regardless of state, including mid-DIV.
- out_valid=0, out_data=0, out_argmax=0, busy=0.
- Counters, sum and divider cleared.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the fixed-point one constant (1<<FRAC) and the width helpers: sum width and divider width.
REQ-030 The divider SHALL be a separate sub-module, seq_divider.
- Parameterised dividend/divisor widths.
- start/done handshake.
- Unsigned restoring algorithm, one quotient bit per cycle.

Verification (defaults N=10, W=16, FRAC=8)
REQ-031 All ten logits 0x0100.
- Result: every out element 0x0019, argmax 0, out_valid at cycle 131.
REQ-032 Logit[3]=0x0400, all others 0x0000.
- Others have x=-4.0, so e=0.
- Result: out[3]=0x0100, others 0x0000, argmax 3.
REQ-033 Logit[0]=0x0000, logit[1]=0xFF80 (-0.5), others 0xF800.
- e1=0x00A0, sum=0x01A0.
- Result: out[0]=0x009D, out[1]=0x0062, others 0, argmax 0.
REQ-034 Logits[2] and [5]=0x0200, others 0xF800.
- Result: out[2]=out[5]=0x0080, argmax 2 (tie rule).
REQ-035 Backpressure: out_ready low for 20 cycles after out_valid.
- out_data stable and in_ready low throughout.
- Raise out_ready: IDLE the next cycle. Change in_data after transfer: no effect on the result.
REQ-036 Reset mid-operation: rst_n low for 1 cycle during DIV.
- All outputs 0 after the edge; in_ready=1 the next cycle.
- A new vector then completes correctly in 131 cycles.
